// File: rtl/filter_sweep_analyzer.sv
// filter_sweep_analyzer: swept-sine frequency-response analyzer.
// Steps the sine generator through a period sweep. Before each step it holds the
// generator and the filters in reset. It then lock-in demodulates every filter
// output against the reference sin/cos over a fixed window. The per-channel I/Q
// sums are streamed out on a valid/ready interface.
//
// Optional feature: define SWEEP_MAG_EN to add res_mag = |res_i| + |res_q|.
//
// Ports:
//   clk, rst (async, active-low)
//   start, abort                           - sweep control
//   period_start/step/stop                 - sweep bounds (unsigned)
//   settle_cycles, meas_cycles             - per-step settle wait and window length
//   ref_sin, ref_cos, dut_in               - reference and filter outputs (signed)
//   gen_period, gen_rst                    - sine generator control (gen_rst active-low)
//   res_valid/res_ready, res_ch, res_period, res_i, res_q [, res_mag] - result stream
//   busy, done                             - status
module filter_sweep_analyzer #(
  parameter int unsigned WORD_WIDTH   = 16,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ACC_WIDTH    = 48,
  parameter int unsigned PERIOD_WIDTH = 16,
  parameter int unsigned CYCLES_WIDTH = 32,
  parameter int unsigned FLUSH_CYCLES = 100,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic        [PERIOD_WIDTH-1:0]      period_start,
  input  logic        [PERIOD_WIDTH-1:0]      period_step,
  input  logic        [PERIOD_WIDTH-1:0]      period_stop,
  input  logic        [CYCLES_WIDTH-1:0]      settle_cycles,
  input  logic        [CYCLES_WIDTH-1:0]      meas_cycles,
  input  logic signed [WORD_WIDTH-1:0]        ref_sin,
  input  logic signed [WORD_WIDTH-1:0]        ref_cos,
  input  logic        [NUM_CH*WORD_WIDTH-1:0] dut_in,
  output logic        [PERIOD_WIDTH-1:0]      gen_period,
  output logic                                gen_rst,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic        [CH_W-1:0]              res_ch,
  output logic        [PERIOD_WIDTH-1:0]      res_period,
  output logic signed [ACC_WIDTH-1:0]         res_i,
  output logic signed [ACC_WIDTH-1:0]         res_q,
`ifdef SWEEP_MAG_EN
  output logic        [ACC_WIDTH:0]           res_mag,
`endif
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned PROD_W = 2 * WORD_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_SETTLE, S_MEASURE, S_REPORT, S_NEXT
  } state_t;

  state_t                      state;
  logic [PERIOD_WIDTH-1:0]     step_r;
  logic [PERIOD_WIDTH-1:0]     stop_r;
  logic [CYCLES_WIDTH-1:0]     settle_r;
  logic [CYCLES_WIDTH-1:0]     meas_r;
  logic [CYCLES_WIDTH-1:0]     cnt;

  logic signed [ACC_WIDTH-1:0] acc_i  [NUM_CH];
  logic signed [ACC_WIDTH-1:0] acc_q  [NUM_CH];
  logic signed [ACC_WIDTH-1:0] snap_i [NUM_CH];
  logic signed [ACC_WIDTH-1:0] snap_q [NUM_CH];
  logic signed [PROD_W-1:0]    prod_i [NUM_CH];
  logic signed [PROD_W-1:0]    prod_q [NUM_CH];
  logic signed [ACC_WIDTH-1:0] sum_i  [NUM_CH];
  logic signed [ACC_WIDTH-1:0] sum_q  [NUM_CH];

  logic [PERIOD_WIDTH:0]       next_sum;
  logic                        last_step;
  logic                        flush_last;
  logic                        settle_last;
  logic                        meas_last;
  logic                        final_ch;
  logic [CH_W-1:0]             nxt_ch;

  // Full-precision products, sign-extended into the wrapping accumulators
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      prod_i[k] = PROD_W'($signed(dut_in[k*WORD_WIDTH +: WORD_WIDTH])) * PROD_W'(ref_sin);
      prod_q[k] = PROD_W'($signed(dut_in[k*WORD_WIDTH +: WORD_WIDTH])) * PROD_W'(ref_cos);
      sum_i[k]  = acc_i[k] + ACC_WIDTH'(prod_i[k]);
      sum_q[k]  = acc_q[k] + ACC_WIDTH'(prod_q[k]);
    end
  end

  // Step and phase termination conditions. The extra bit of next_sum catches period wrap.
  always_comb begin
    next_sum    = {1'b0, gen_period} + {1'b0, step_r};
    last_step   = (step_r == '0) || next_sum[PERIOD_WIDTH] ||
                  (next_sum[PERIOD_WIDTH-1:0] > stop_r);
    flush_last  = (cnt == CYCLES_WIDTH'(FLUSH_CYCLES - 1));
    settle_last = (cnt == settle_r - CYCLES_WIDTH'(1));
    meas_last   = (meas_r == '0) || (cnt == meas_r - CYCLES_WIDTH'(1));
    final_ch    = (res_ch == CH_W'(NUM_CH - 1));
    nxt_ch      = res_ch + CH_W'(1);
  end

  // Sweep sequencer with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      step_r     <= '0;
      stop_r     <= '0;
      settle_r   <= '0;
      meas_r     <= '0;
      cnt        <= '0;
      gen_period <= '0;
      gen_rst    <= 1'b0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_period <= '0;
      res_i      <= '0;
      res_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_i[k]  <= '0;
        acc_q[k]  <= '0;
        snap_i[k] <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort drops everything in flight; no done pulse
        state     <= S_IDLE;
        res_valid <= 1'b0;
        gen_rst   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              step_r     <= period_step;
              stop_r     <= period_stop;
              settle_r   <= settle_cycles;
              meas_r     <= meas_cycles;
              gen_period <= period_start;
              cnt        <= '0;
              busy       <= 1'b1;
              gen_rst    <= 1'b0;
              state      <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            for (int k = 0; k < NUM_CH; k++) begin
              acc_i[k] <= '0;
              acc_q[k] <= '0;
            end
            if (flush_last) begin
              gen_rst <= 1'b1;
              cnt     <= '0;
              state   <= (settle_r == '0) ? S_MEASURE : S_SETTLE;
            end else begin
              cnt <= cnt + CYCLES_WIDTH'(1);
            end
          end
          S_SETTLE: begin
            for (int k = 0; k < NUM_CH; k++) begin
              acc_i[k] <= '0;
              acc_q[k] <= '0;
            end
            if (settle_last) begin
              cnt   <= '0;
              state <= S_MEASURE;
            end else begin
              cnt <= cnt + CYCLES_WIDTH'(1);
            end
          end
          S_MEASURE: begin
            for (int k = 0; k < NUM_CH; k++) begin
              acc_i[k] <= sum_i[k];
              acc_q[k] <= sum_q[k];
            end
            if (meas_last) begin
              // Snapshot includes this cycle's product; channel 0 goes out immediately
              for (int k = 0; k < NUM_CH; k++) begin
                snap_i[k] <= sum_i[k];
                snap_q[k] <= sum_q[k];
              end
              res_valid  <= 1'b1;
              res_ch     <= '0;
              res_i      <= sum_i[0];
              res_q      <= sum_q[0];
              res_period <= gen_period;
              state      <= S_REPORT;
            end else begin
              cnt <= cnt + CYCLES_WIDTH'(1);
            end
          end
          S_REPORT: begin
            if (res_ready) begin
              if (final_ch) begin
                res_valid <= 1'b0;
                done      <= last_step;
                state     <= S_NEXT;
              end else begin
                res_ch <= nxt_ch;
                res_i  <= snap_i[nxt_ch];
                res_q  <= snap_q[nxt_ch];
              end
            end
          end
          S_NEXT: begin
            gen_rst <= 1'b0;
            cnt     <= '0;
            if (last_step) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              gen_period <= next_sum[PERIOD_WIDTH-1:0];
              state      <= S_FLUSH;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SWEEP_MAG_EN
  logic [ACC_WIDTH-1:0] abs_i;
  logic [ACC_WIDTH-1:0] abs_q;

  // L1 magnitude; the most negative value maps to 2^(ACC_WIDTH-1) without overflow
  always_comb begin
    abs_i   = res_i[ACC_WIDTH-1] ? ACC_WIDTH'(-res_i) : ACC_WIDTH'(res_i);
    abs_q   = res_q[ACC_WIDTH-1] ? ACC_WIDTH'(-res_q) : ACC_WIDTH'(res_q);
    res_mag = {1'b0, abs_i} + {1'b0, abs_q};
  end
`endif

endmodule

// File: tb/tb_filter_sweep_analyzer.sv
// Testbench for filter_sweep_analyzer. The stimulus process builds expected
// results from plain-arithmetic dot products. A negedge monitor pops and
// compares them whenever a result is handed off.
module tb_filter_sweep_analyzer;

  localparam int NCH   = 2;
  localparam int W     = 16;
  localparam int A     = 48;
  localparam int FLUSH = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, abort;
  logic [15:0]       period_start, period_step, period_stop;
  logic [31:0]       settle_cycles, meas_cycles;
  logic [W-1:0]      ref_sin, ref_cos;
  logic [NCH*W-1:0]  dut_in;
  logic [15:0]       gen_period;
  logic              gen_rst, res_valid, res_ready;
  logic [0:0]        res_ch;
  logic [15:0]       res_period;
  logic [A-1:0]      res_i, res_q;
`ifdef SWEEP_MAG_EN
  logic [A:0]        res_mag;
`endif
  logic              busy, done;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  int exp_done  = 0;

  typedef struct {
    int          ch;
    logic [15:0] period;
    logic [A-1:0] i;
    logic [A-1:0] q;
  } res_t;
  res_t exp_q[$];

  always #5 clk = ~clk;

  filter_sweep_analyzer #(
    .WORD_WIDTH(W), .NUM_CH(NCH), .ACC_WIDTH(A), .PERIOD_WIDTH(16),
    .CYCLES_WIDTH(32), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .period_start(period_start), .period_step(period_step), .period_stop(period_stop),
    .settle_cycles(settle_cycles), .meas_cycles(meas_cycles),
    .ref_sin(ref_sin), .ref_cos(ref_cos), .dut_in(dut_in),
    .gen_period(gen_period), .gen_rst(gen_rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_period(res_period), .res_i(res_i), .res_q(res_q),
`ifdef SWEEP_MAG_EN
    .res_mag(res_mag),
`endif
    .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data(input bit fixed);
    if (fixed) begin
      ref_sin = 16'h4000;
      ref_cos = 16'h4000;
      dut_in  = {16'hC000, 16'h4000};
    end else begin
      ref_sin = 16'($urandom);
      ref_cos = 16'($urandom);
      for (int k = 0; k < NCH; k++) dut_in[k*W +: W] = 16'($urandom);
    end
  endtask

  // Config junk and stray start pulses while busy must be ignored
  task automatic junk_cfg();
    period_start  = 16'($urandom);
    period_step   = 16'($urandom);
    period_stop   = 16'($urandom);
    settle_cycles = $urandom;
    meas_cycles   = $urandom;
    start         = ($urandom_range(0, 3) == 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gen_period"}, 64'(gen_period), 64'd0);
    chk({tag, "_gen_rst"},    64'(gen_rst),    64'd0);
    chk({tag, "_res_valid"},  64'(res_valid),  64'd0);
    chk({tag, "_res_ch"},     64'(res_ch),     64'd0);
    chk({tag, "_res_period"}, 64'(res_period), 64'd0);
    chk({tag, "_res_i"},      64'(res_i),      64'd0);
    chk({tag, "_res_q"},      64'(res_q),      64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
  endtask

  task automatic run_sweep(input logic [15:0] ps, input logic [15:0] pst, input logic [15:0] psp,
                           input int settle, input int meas, input bit fixed, input bit rdy1,
                           input int stall_in, input int abort_m, input bit rst_rep);
    logic [15:0] periods[$];
    logic [15:0] p;
    logic [16:0] nx;
    longint      ai[NCH];
    longint      aq[NCH];
    int          low, mc, acc, it, stall;
    res_t        e;
    stall = stall_in;
    // Expected period list straight from the sweep rule
    p = ps;
    forever begin
      periods.push_back(p);
      nx = {1'b0, p} + {1'b0, pst};
      if (pst == 16'd0 || nx[16] || nx[15:0] > psp) break;
      p = nx[15:0];
    end
    drive_data(fixed);
    period_start  = ps;
    period_step   = pst;
    period_stop   = psp;
    settle_cycles = 32'(settle);
    meas_cycles   = 32'(meas);
    abort         = 1'b0;
    res_ready     = 1'b0;
    start         = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_gen_rst", 64'(gen_rst), 64'd0);
    foreach (periods[s]) begin
      low = 0;
      repeat (FLUSH + settle) begin
        if (!gen_rst) low++;
        drive_data(fixed);
        junk_cfg();
        res_ready = 1'($urandom);
        tick();
      end
      mc = (meas == 0) ? 1 : meas;
      for (int k = 0; k < NCH; k++) begin
        ai[k] = 0;
        aq[k] = 0;
      end
      for (int m = 0; m < mc; m++) begin
        if (!gen_rst) low++;
        drive_data(fixed);
        junk_cfg();
        res_ready = 1'($urandom);
        for (int k = 0; k < NCH; k++) begin
          ai[k] += longint'($signed(dut_in[k*W +: W])) * longint'($signed(ref_sin));
          aq[k] += longint'($signed(dut_in[k*W +: W])) * longint'($signed(ref_cos));
        end
        if (m == abort_m) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          start = 1'b0;
          chk("abort_busy", 64'(busy), 64'd0);
          chk("abort_gen_rst", 64'(gen_rst), 64'd0);
          chk("abort_res_valid", 64'(res_valid), 64'd0);
          repeat (4) begin
            chk("abort_idle_valid", 64'(res_valid), 64'd0);
            chk("abort_idle_done", 64'(done), 64'd0);
            drive_data(fixed);
            tick();
          end
          chk("abort_done_count", 64'(done_seen), 64'(exp_done));
          return;
        end
        tick();
      end
      chk("flush_len", 64'(low), 64'(FLUSH));
      for (int k = 0; k < NCH; k++) begin
        e.ch     = k;
        e.period = periods[s];
        e.i      = A'(ai[k]);
        e.q      = A'(aq[k]);
        exp_q.push_back(e);
      end
      acc = 0;
      it  = 0;
      while (acc < NCH && it < 64) begin
        chk("report_valid", 64'(res_valid), 64'd1);
        drive_data(fixed);
        junk_cfg();
        if (stall > 0) begin
          res_ready = 1'b0;
          stall--;
        end else begin
          res_ready = rdy1 ? 1'b1 : 1'($urandom);
        end
        if (rst_rep && it == 1) begin
          res_ready = 1'b0;
          #2 rst = 1'b0;
          #1 check_reset_outputs("mid_rst");
          exp_q.delete();
          tick();
          tick();
          rst   = 1'b1;
          start = 1'b0;
          tick();
          check_reset_outputs("post_rst");
          return;
        end
        if (res_ready) acc++;
        it++;
        tick();
      end
      chk("report_accepted", 64'(acc), 64'(NCH));
      chk("next_done", 64'(done), 64'(s == periods.size() - 1));
      chk("next_busy", 64'(busy), 64'd1);
      drive_data(fixed);
      junk_cfg();
      res_ready = 1'b0;
      tick();
    end
    start = 1'b0;
    exp_done++;
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_done", 64'(done), 64'd0);
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'(exp_done));
  endtask

  // Scoreboard monitor: compare each accepted result, and check that words hold while stalled
  logic         hold_v = 1'b0;
  logic [0:0]   hold_ch;
  logic [A-1:0] hold_i, hold_q;
  res_t         m_e;
  longint       m_vi, m_vq;

  always @(negedge clk) begin
    if (!rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_ch", 64'(res_ch), 64'(hold_ch));
        chk("hold_i", 64'(res_i), 64'(hold_i));
        chk("hold_q", 64'(res_q), 64'(hold_q));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=ch%0d required=none", res_ch);
        end else begin
          m_e = exp_q.pop_front();
          chk("res_ch", 64'(res_ch), 64'(m_e.ch));
          chk("res_period", 64'(res_period), 64'(m_e.period));
          chk("res_i", 64'(res_i), 64'(m_e.i));
          chk("res_q", 64'(res_q), 64'(m_e.q));
`ifdef SWEEP_MAG_EN
          m_vi = longint'($signed(m_e.i));
          m_vq = longint'($signed(m_e.q));
          chk("res_mag", 64'(res_mag),
              64'((m_vi < 0 ? -m_vi : m_vi) + (m_vq < 0 ? -m_vq : m_vq)));
`endif
        end
      end
      hold_v  = res_valid && !res_ready;
      hold_ch = res_ch;
      hold_i  = res_i;
      hold_q  = res_q;
      if (done) done_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rs, rst_step, rsp;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    res_ready = 1'b0;
    period_start = '0;
    period_step = '0;
    period_stop = '0;
    settle_cycles = '0;
    meas_cycles = '0;
    ref_sin = '0;
    ref_cos = '0;
    dut_in = '0;
    #3 check_reset_outputs("reset");
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Known-value single step: ch0 +0x80000000, ch1 -0x80000000
    run_sweep(16'd5, 16'd1, 16'd5, 0, 8, 1'b1, 1'b1, 0, -1, 1'b0);
    // Multi-step sweep 2,7,12,17 with ready tied high
    run_sweep(16'd2, 16'd5, 16'd20, 3, 4, 1'b0, 1'b1, 0, -1, 1'b0);
    // Ten-cycle stall at the start of REPORT, random ready afterwards
    run_sweep(16'd100, 16'd50, 16'd160, 1, 3, 1'b0, 1'b0, 10, -1, 1'b0);
    // Abort in the middle of MEASURE, then a clean sweep with meas=0
    run_sweep(16'd10, 16'd1, 16'd12, 2, 6, 1'b0, 1'b0, 0, 3, 1'b0);
    run_sweep(16'd30, 16'd2, 16'd33, 0, 0, 1'b0, 1'b1, 0, -1, 1'b0);
    // Period overflow, zero step, start beyond stop: one step each
    run_sweep(16'hFFF0, 16'h0020, 16'hFFFF, 0, 2, 1'b0, 1'b1, 0, -1, 1'b0);
    run_sweep(16'd7, 16'd0, 16'd100, 1, 2, 1'b0, 1'b0, 0, -1, 1'b0);
    run_sweep(16'd50, 16'd1, 16'd10, 0, 3, 1'b0, 1'b1, 0, -1, 1'b0);
    // Reset in the middle of REPORT, then recovery
    run_sweep(16'd3, 16'd1, 16'd4, 0, 2, 1'b0, 1'b1, 0, -1, 1'b1);
    run_sweep(16'd4, 16'd3, 16'd10, 2, 5, 1'b0, 1'b0, 0, -1, 1'b0);
    // Random sweeps
    for (int n = 0; n < 4; n++) begin
      rs       = 16'($urandom_range(0, 100));
      rst_step = 16'($urandom_range(1, 30));
      rsp      = rs + 16'($urandom_range(0, 60));
      run_sweep(rs, rst_step, rsp, $urandom_range(0, 4), $urandom_range(0, 10),
                1'b0, 1'b0, 0, -1, 1'b0);
    end
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
